grf_write_arbiter: RTL and testbench
====================================

Name: grf_write_arbiter

Overview:
- Initiator side of the general register file write port: owns A3/WD/WE/PCW and drives them into the GRF every cycle.
- Merges two write sources. The W-stage pipeline write must never stall. A secondary write port, for multi-cycle MDU results and late loads, is buffered in a small FIFO.
- Exports a pending-register mask so the decode stage can stall on registers whose queued write has not committed yet.

Parameters:
- DEPTH, 4, secondary FIFO entries; power of two, 2..16.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Clr_n  in  1  asynchronous active-low reset.
- WEW  in  1  W-stage write request.
- A3W  in  5  W-stage destination register.
- WDW  in  32  W-stage write data.
- PCWW  in  32  W-stage instruction PC, used for trace.
- ReqS  in  1  secondary write request.
- A3S  in  5  secondary destination register.
- WDS  in  32  secondary write data.
- PCS  in  32  secondary instruction PC.
- AckS  out  1  secondary request accepted this cycle.
- WE  out  1  GRF write enable, registered.
- A3  out  5  GRF write address, registered.
- WD  out  32  GRF write data, registered.
- PCW  out  32  PC of the committed write, registered.
- PendMask  out  32  bit r = 1 while any valid FIFO entry targets register r.
- Count  out  AW+1  FIFO occupancy, including squashed entries not yet popped.

Behaviour:
- Reset (Clr_n=0, asynchronous): WE=0, A3=0, WD=0, PCW=0, FIFO empty, Count=0, all valid bits cleared, PendMask=0. Reset mid-drain discards all queued entries.
- Effective requests: a request to register $0 is treated as no request. A $0 request from ReqS is still acknowledged (AckS=1) and then discarded.
- Output selection each cycle (result registered, visible next cycle):
  - First priority: W-stage, if WEW && A3W!=0.
  - Otherwise the FIFO head, if the FIFO is non-empty and the head is valid.
  - Otherwise bypass: ReqS with the FIFO empty is written directly and not enqueued.
  - Otherwise WE=0. A3/WD/PCW hold their previous values.
- Latency:
  - W-stage write: 1 cycle.
  - Secondary write with bypass: 1 cycle.
  - Queued write: at least 2 cycles.
- AckS: combinational. AckS = ReqS && (bypass taken || Count<DEPTH).
  - No enqueue-while-full pass-through, even if the FIFO pops that cycle.
  - When AckS=0 the requester holds ReqS, A3S, WDS and PCS stable.
- Enqueue: happens when ReqS && AckS && !bypass. The entry is stored at the tail with valid=1.
- Ordering and squash:
  - Queued entries are older in program order than the current W-stage write.
  - A W-stage write to r clears the valid bit of every FIFO entry targeting r in the same edge.
  - An entry enqueued in that same cycle is also squashed if it targets r.
- Pop rules:
  - An invalid head pops every cycle, regardless of the W-stage, and produces no write.
  - A valid head pops only when it is selected for output.
  - Enqueue and pop may occur together; Count is then unchanged.
- Wrap-around: head and tail pointers are AW bits and wrap modulo DEPTH. Full/empty is decided from Count, not from pointer equality.
- PendMask: combinational OR over valid entries of onehot(addr). The bypass path never sets PendMask.
- No back-pressure exists toward the W-stage. WEW is always accepted.

Optional Feature:
- Macro: GRF_WRITE_TRACE_EN.
- Defined: on every rising edge where a write is selected, simulation prints "@%h: $%d <= %h" with PC, address and data. Squashed pops print "squash $%d @%h".
- Undefined: no $display. Behaviour is otherwise identical, and the block is synthesis-clean.

Decomposition:
- Shared package constants: REG_ZERO=5'd0, GRF_AW=5, GRF_DW=32, plus the FIFO entry record layout {valid, addr[4:0], data[31:0], pc[31:0]}.
- One natural sub-module, grf_wq_fifo. It holds the storage array, pointers, Count, per-entry valid bits and the squash-by-address port.
- The top module holds the output select mux, the output registers and the trace logic.

Test Plan:
- W-only: WEW=1, A3W=5, WDW=32'h1234 → next cycle WE=1, A3=5, WD=32'h1234; AckS not involved.
- Bypass: FIFO empty, WEW=0, ReqS=1, A3S=8, WDS=32'hAA → AckS=1, next cycle WE=1, A3=8, Count stays 0.
- Conflict/queue: WEW=1 (A3W=3) plus ReqS (A3S=9) for 1 cycle, then WEW=0 → $3 written at cycle+1, $9 at cycle+2; PendMask[9]=1 for exactly 1 cycle.
- Full: hold WEW=1 (A3W=1) and issue DEPTH+1 secondary requests → AckS=0 on request DEPTH+1, Count=DEPTH; release WEW → entries drain in FIFO order, one per cycle.
- Squash: queue A3S=7 with WDS=32'h77, then WEW=1 with A3W=7, WDW=32'h99 → only 32'h99 is written to $7; the stale entry pops with no write; PendMask[7] clears.
- $0 and reset: ReqS with A3S=0 → AckS=1, no WE. Assert Clr_n=0 asynchronously with 3 entries queued → WE=0 and Count=0 immediately, with no subsequent writes.

Source files
------------

// File: rtl/grf_write_arbiter_pkg.sv
// Shared constants and the write-queue entry layout for the GRF write arbiter.
package grf_write_arbiter_pkg;

    localparam int GRF_AW = 5;
    localparam int GRF_DW = 32;
    localparam logic [GRF_AW-1:0] REG_ZERO = 5'd0;

    // One queued secondary write; valid drops when squashed or popped.
    typedef struct packed {
        logic              valid;
        logic [GRF_AW-1:0] addr;
        logic [GRF_DW-1:0] data;
        logic [31:0]       pc;
    } wq_entry_t;

endpackage

// File: rtl/grf_wq_fifo.sv
// Secondary write queue: storage, pointers, occupancy, per-entry valid bits
// and squash-by-address. Valid bits are cleared on pop so that only occupied
// slots can ever be valid, which lets the pending mask scan every slot.
module grf_wq_fifo
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [GRF_AW-1:0] push_addr,
    input  logic [GRF_DW-1:0] push_data,
    input  logic [31:0]       push_pc,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [GRF_AW-1:0] squash_addr,
    output wq_entry_t         head,
    output logic [AW:0]       count,
    output logic [31:0]       pend_mask
);

    logic [DEPTH-1:0]  vld;
    logic [GRF_AW-1:0] addr_q [DEPTH];
    logic [GRF_DW-1:0] data_q [DEPTH];
    logic [31:0]       pc_q   [DEPTH];
    logic [AW-1:0]     head_ptr;
    logic [AW-1:0]     tail_ptr;

    // Control state: pointers, count, valid bits (squash, pop, push in priority order).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld      <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && addr_q[i] == squash_addr) vld[i] <= 1'b0;
            end
            if (pop) begin
                vld[head_ptr] <= 1'b0;
                head_ptr      <= head_ptr + AW'(1);
            end
            // An entry arriving alongside a W-stage write to the same register is already stale.
            if (push) begin
                vld[tail_ptr] <= !(squash_en && push_addr == squash_addr);
                tail_ptr      <= tail_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Payload storage; needs no reset because valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_ptr] <= push_addr;
            data_q[tail_ptr] <= push_data;
            pc_q[tail_ptr]   <= push_pc;
        end
    end

    assign head = {vld[head_ptr], addr_q[head_ptr], data_q[head_ptr], pc_q[head_ptr]};

    // Pending mask: onehot of every still-valid queued destination.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) pend_mask[addr_q[i]] = 1'b1;
        end
    end

endmodule

// File: rtl/grf_write_arbiter.sv
// GRF write-port arbiter: W-stage writes never stall; secondary writes bypass
// when the queue is empty and idle, otherwise queue in grf_wq_fifo.
// Optional trace printing is enabled with GRF_WRITE_TRACE_EN.
module grf_write_arbiter
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              WEW,
    input  logic [GRF_AW-1:0] A3W,
    input  logic [GRF_DW-1:0] WDW,
    input  logic [31:0]       PCWW,
    input  logic              ReqS,
    input  logic [GRF_AW-1:0] A3S,
    input  logic [GRF_DW-1:0] WDS,
    input  logic [31:0]       PCS,
    output logic              AckS,
    output logic              WE,
    output logic [GRF_AW-1:0] A3,
    output logic [GRF_DW-1:0] WD,
    output logic [31:0]       PCW,
    output logic [31:0]       PendMask,
    output logic [AW:0]       Count
);

    wq_entry_t head;
    logic      w_eff, s_eff, empty, not_full;
    logic      sel_w, sel_h, bypass, push, pop;

    assign w_eff    = WEW && (A3W != REG_ZERO);
    assign s_eff    = ReqS && (A3S != REG_ZERO);
    assign empty    = (Count == '0);
    assign not_full = (Count < (AW+1)'(DEPTH));

    // Priority: W-stage, then a valid queue head, then direct bypass.
    assign sel_w  = w_eff;
    assign sel_h  = !w_eff && !empty && head.valid;
    assign bypass = !w_eff && empty && s_eff;

    assign AckS = ReqS && (bypass || not_full);
    // $0 requests are acknowledged but never stored.
    assign push = s_eff && AckS && !bypass;
    // Stale heads drain unconditionally; valid heads leave only when written.
    assign pop  = !empty && (!head.valid || sel_h);

    grf_wq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk         (Clk),
        .rst_n       (Clr_n),
        .push        (push),
        .push_addr   (A3S),
        .push_data   (WDS),
        .push_pc     (PCS),
        .pop         (pop),
        .squash_en   (w_eff),
        .squash_addr (A3W),
        .head        (head),
        .count       (Count),
        .pend_mask   (PendMask)
    );

    // Output registers; address/data/PC hold when nothing is written.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            WE  <= 1'b0;
            A3  <= '0;
            WD  <= '0;
            PCW <= '0;
        end else begin
            WE <= sel_w || sel_h || bypass;
            if (sel_w) begin
                A3 <= A3W; WD <= WDW; PCW <= PCWW;
            end else if (sel_h) begin
                A3 <= head.addr; WD <= head.data; PCW <= head.pc;
            end else if (bypass) begin
                A3 <= A3S; WD <= WDS; PCW <= PCS;
            end
        end
    end

`ifdef GRF_WRITE_TRACE_EN
    // Simulation trace of every selected write and every stale-entry drop.
    always_ff @(posedge Clk) begin
        if (Clr_n) begin
            if (sel_w)       $display("@%h: $%d <= %h", PCWW, A3W, WDW);
            else if (sel_h)  $display("@%h: $%d <= %h", head.pc, head.addr, head.data);
            else if (bypass) $display("@%h: $%d <= %h", PCS, A3S, WDS);
            if (pop && !head.valid) $display("squash $%d @%h", head.addr, head.pc);
        end
    end
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter (DEPTH=4).
module tb_grf_write_arbiter;

    logic        Clk, Clr_n;
    logic        WEW, ReqS, AckS, WE;
    logic [4:0]  A3W, A3S, A3;
    logic [31:0] WDW, PCWW, WDS, PCS, WD, PCW, PendMask;
    logic [2:0]  Count;

    int n_tot  = 0;
    int n_pass = 0;

    grf_write_arbiter #(.DEPTH(4), .AW(2)) dut (
        .Clk(Clk), .Clr_n(Clr_n),
        .WEW(WEW), .A3W(A3W), .WDW(WDW), .PCWW(PCWW),
        .ReqS(ReqS), .A3S(A3S), .WDS(WDS), .PCS(PCS),
        .AckS(AckS), .WE(WE), .A3(A3), .WD(WD), .PCW(PCW),
        .PendMask(PendMask), .Count(Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_w(input logic en, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        WEW = en; A3W = a; WDW = d; PCWW = pc;
    endtask

    task automatic drive_s(input logic en, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        ReqS = en; A3S = a; WDS = d; PCS = pc;
    endtask

    initial begin
        Clr_n = 1'b0;
        drive_w(0, 0, 0, 0);
        drive_s(0, 0, 0, 0);
        #12;
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_pcw", PCW, 32'd0);
        chk("rst_cnt", 32'(Count), 32'd0);
        chk("rst_pend", PendMask, 32'd0);
        Clr_n = 1'b1;
        tick();

        // W-stage only
        drive_w(1, 5, 32'h1234, 32'h100);
        tick();
        chk("w_we", 32'(WE), 32'd1);
        chk("w_a3", 32'(A3), 32'd5);
        chk("w_wd", WD, 32'h1234);
        chk("w_pc", PCW, 32'h100);
        drive_w(0, 0, 0, 0);
        tick();
        chk("idle_we", 32'(WE), 32'd0);
        chk("idle_hold_a3", 32'(A3), 32'd5);

        // Bypass with empty queue
        drive_s(1, 8, 32'hAA, 32'h200);
        #1 chk("byp_ack", 32'(AckS), 32'd1);
        tick();
        chk("byp_we", 32'(WE), 32'd1);
        chk("byp_a3", 32'(A3), 32'd8);
        chk("byp_wd", WD, 32'hAA);
        chk("byp_cnt", 32'(Count), 32'd0);
        chk("byp_pend", PendMask, 32'd0);

        // Conflict: W-stage wins, secondary queues
        drive_w(1, 3, 32'h33, 32'h300);
        drive_s(1, 9, 32'h99, 32'h304);
        #1 chk("cf_ack", 32'(AckS), 32'd1);
        chk("cf_pend_pre", PendMask, 32'd0);
        tick();
        chk("cf_a3_w", 32'(A3), 32'd3);
        chk("cf_cnt", 32'(Count), 32'd1);
        chk("cf_pend", PendMask, 32'h200);
        drive_w(0, 0, 0, 0);
        drive_s(0, 0, 0, 0);
        tick();
        chk("cf_we_q", 32'(WE), 32'd1);
        chk("cf_a3_q", 32'(A3), 32'd9);
        chk("cf_wd_q", WD, 32'h99);
        chk("cf_pc_q", PCW, 32'h304);
        chk("cf_cnt0", 32'(Count), 32'd0);
        chk("cf_pend0", PendMask, 32'd0);

        // Fill to full behind a busy W-stage
        drive_w(1, 1, 32'h1, 32'h400);
        for (int i = 0; i < 5; i++) begin
            drive_s(1, 5'(10 + i), 32'hA0 + 32'(i), 32'h500 + 32'(i));
            #1 chk($sformatf("full_ack%0d", i), 32'(AckS), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("full_cnt", 32'(Count), 32'd4);
        chk("full_pend", PendMask, 32'h3C00);
        chk("full_a3_w", 32'(A3), 32'd1);
        drive_s(0, 0, 0, 0);
        drive_w(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("drain_we%0d", k), 32'(WE), 32'd1);
            chk($sformatf("drain_a3_%0d", k), 32'(A3), 32'(10 + k));
            chk($sformatf("drain_wd%0d", k), WD, 32'hA0 + 32'(k));
        end
        chk("drain_cnt", 32'(Count), 32'd0);
        tick();
        chk("drain_idle", 32'(WE), 32'd0);

        // Squash a queued write by a younger W-stage write
        drive_w(1, 2, 32'h22, 32'h600);
        drive_s(1, 7, 32'h77, 32'h604);
        tick();
        chk("sq_cnt1", 32'(Count), 32'd1);
        chk("sq_pend1", PendMask, 32'h80);
        drive_s(0, 0, 0, 0);
        drive_w(1, 7, 32'h99, 32'h608);
        tick();
        chk("sq_a3", 32'(A3), 32'd7);
        chk("sq_wd", WD, 32'h99);
        chk("sq_pend0", PendMask, 32'd0);
        chk("sq_cnt_stale", 32'(Count), 32'd1);
        drive_w(0, 0, 0, 0);
        tick();
        chk("sq_pop_we", 32'(WE), 32'd0);
        chk("sq_pop_cnt", 32'(Count), 32'd0);
        chk("sq_hold_wd", WD, 32'h99);

        // $0 secondary request
        drive_s(1, 0, 32'h55, 32'h700);
        #1 chk("z_ack", 32'(AckS), 32'd1);
        tick();
        chk("z_we", 32'(WE), 32'd0);
        chk("z_cnt", 32'(Count), 32'd0);
        drive_s(0, 0, 0, 0);

        // Async reset with three entries queued
        drive_w(1, 4, 32'h44, 32'h800);
        for (int i = 0; i < 3; i++) begin
            drive_s(1, 5'(20 + i), 32'hC0 + 32'(i), 32'h900);
            tick();
        end
        drive_s(0, 0, 0, 0);
        drive_w(0, 0, 0, 0);
        chk("ar_cnt3", 32'(Count), 32'd3);
        chk("ar_we1", 32'(WE), 32'd1);
        #3 Clr_n = 1'b0;
        #1;
        chk("ar_we", 32'(WE), 32'd0);
        chk("ar_cnt", 32'(Count), 32'd0);
        chk("ar_pend", PendMask, 32'd0);
        chk("ar_a3", 32'(A3), 32'd0);
        #2 Clr_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ar_nowr%0d", k), 32'(WE), 32'd0);
        end
        chk("ar_cnt_end", 32'(Count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
